// File: rtl/rvm_shift_unit.sv
// rvm_shift_unit: iterative barrel-less shifter serving the control FSM's
// f_shf_* request/response interface. An accepted request latches the
// operands, shifts the accumulator one bit per cycle until the shift amount
// is exhausted, then presents the result together with a one-cycle valid
// pulse.
//
// Optional build macro: RVM_SHIFT_FAST_EN
//   When defined, the SHIFT state consumes four bits of shift amount per
//   cycle while at least four remain, falling back to single-bit steps for
//   the remainder. Results are identical in both builds; only latency
//   changes.
module rvm_shift_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            f_shf_req,
    input  logic [XLEN-1:0] f_shf_lhs,
    input  logic [XLEN-1:0] f_shf_rhs,
    input  logic [1:0]      f_shf_op,
    output logic            f_shf_valid,
    output logic [XLEN-1:0] f_shf_result,
    output logic            f_shf_busy
);

    // Operation encodings presented on f_shf_op.
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t               r_state;
    logic [XLEN-1:0]      r_acc;
    logic [SHAMT_W-1:0]   r_count;
    logic [1:0]           r_op;
    logic                 r_valid;
    logic [XLEN-1:0]      r_result;

    logic [SHAMT_W-1:0]   w_reqShamt;
    logic                 w_reqNeedsShift;
    logic [XLEN-1:0]      w_shiftOne;
    logic [XLEN-1:0]      w_accStep;
    logic [SHAMT_W-1:0]   w_countStep;
    logic                 w_unusedRhs;

    // Only the low SHAMT_W bits of rhs carry the shift amount; the upper
    // bits are deliberately ignored, so 0x20 behaves as a zero shift.
    assign w_reqShamt      = f_shf_rhs[SHAMT_W-1:0];
    assign w_unusedRhs     = ^f_shf_rhs[XLEN-1:SHAMT_W];

    // A request only needs the SHIFT state when there is something to shift
    // and the op is a real one; the reserved op passes lhs straight through.
    assign w_reqNeedsShift = (w_reqShamt != '0) && (f_shf_op != OP_RSV);

    // Single-bit step of the accumulator using the latched op's fill rule.
    always_comb begin
        w_shiftOne = r_acc;
        case (r_op)
            OP_SLL:  w_shiftOne = {r_acc[XLEN-2:0], 1'b0};
            OP_SRL:  w_shiftOne = {1'b0, r_acc[XLEN-1:1]};
            OP_SRA:  w_shiftOne = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
            default: w_shiftOne = r_acc;
        endcase
    end

`ifdef RVM_SHIFT_FAST_EN
    logic [XLEN-1:0] w_shiftFour;

    // Four-bit step, same fill rules as the single-bit path.
    always_comb begin
        w_shiftFour = r_acc;
        case (r_op)
            OP_SLL:  w_shiftFour = {r_acc[XLEN-5:0], 4'b0000};
            OP_SRL:  w_shiftFour = {4'b0000, r_acc[XLEN-1:4]};
            OP_SRA:  w_shiftFour = {{4{r_acc[XLEN-1]}}, r_acc[XLEN-1:4]};
            default: w_shiftFour = r_acc;
        endcase
    end

    // Take the wide step whenever at least four bits remain, else one bit.
    always_comb begin
        w_accStep   = w_shiftOne;
        w_countStep = '0;
        if (r_count >= SHAMT_W'(4)) begin
            w_accStep   = w_shiftFour;
            w_countStep = r_count - SHAMT_W'(4);
        end else if (r_count != '0) begin
            w_countStep = r_count - SHAMT_W'(1);
        end
    end
`else
    // One bit per cycle; the count only decrements while nonzero so it can
    // never wrap around.
    always_comb begin
        w_accStep   = w_shiftOne;
        w_countStep = '0;
        if (r_count != '0) begin
            w_countStep = r_count - SHAMT_W'(1);
        end
    end
`endif

    // Control FSM with registered valid/result; the result register is loaded
    // on the edge that enters DONE so it is valid alongside the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_count  <= '0;
            r_op     <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (f_shf_req) begin
                        r_acc   <= f_shf_lhs;
                        r_count <= w_reqShamt;
                        r_op    <= f_shf_op;
                        if (w_reqNeedsShift) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state  <= ST_DONE;
                            r_valid  <= 1'b1;
                            r_result <= f_shf_lhs;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_acc   <= w_accStep;
                    r_count <= w_countStep;
                    if (w_countStep == '0) begin
                        r_state  <= ST_DONE;
                        r_valid  <= 1'b1;
                        r_result <= w_accStep;
                    end
                end
                ST_DONE: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign f_shf_valid  = r_valid;
    assign f_shf_result = r_result;
    assign f_shf_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rvm_shift_unit.sv
// tb_rvm_shift_unit: directed testbench for rvm_shift_unit. Expected results
// and pulse timing are hand-computed; latency follows RVM_SHIFT_FAST_EN when
// the bench is compiled with that macro.
module tb_rvm_shift_unit;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic        clk;
    logic        reset;
    logic        shfReq;
    logic [31:0] shfLhs;
    logic [31:0] shfRhs;
    logic [1:0]  shfOp;
    logic        shfValid;
    logic [31:0] shfResult;
    logic        shfBusy;

    int nAsserts;
    int nFail;

    rvm_shift_unit dut (
        .clk          (clk),
        .reset        (reset),
        .f_shf_req    (shfReq),
        .f_shf_lhs    (shfLhs),
        .f_shf_rhs    (shfRhs),
        .f_shf_op     (shfOp),
        .f_shf_valid  (shfValid),
        .f_shf_result (shfResult),
        .f_shf_busy   (shfBusy)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle in which valid is expected, counting the request edge as cycle 0.
    function automatic int expLatency(input logic [1:0] op, input logic [31:0] rhs);
        int k;
        k = int'(rhs[4:0]);
        if (op == OP_RSV || k == 0) return 1;
`ifdef RVM_SHIFT_FAST_EN
        return (k / 4) + (k % 4) + 1;
`else
        return k + 1;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one rising edge; returns in cycle 1.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] lhs, input logic [31:0] rhs);
        shfReq = 1'b1;
        shfOp  = op;
        shfLhs = lhs;
        shfRhs = rhs;
        step();
        shfReq = 1'b0;
        shfLhs = 32'hDEAD_BEEF;
        shfRhs = 32'hFFFF_FFFF;
        shfOp  = OP_SRA;
    endtask

    // Issue one operation and check busy/valid every cycle, the result in the
    // valid cycle, and the idle cycle that follows. intrudeCycle != 0 raises a
    // conflicting request during that busy cycle.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] lhs,
                         input logic [31:0] rhs, input logic [31:0] expResult,
                         input int intrudeCycle);
        int lat;
        lat = expLatency(op, rhs);
        applyStimulus(op, lhs, rhs);
        for (int c = 1; c <= lat; c++) begin
            checkOutput({tag, "_busy"}, {31'b0, shfBusy}, 32'd1);
            checkOutput({tag, "_valid"}, {31'b0, shfValid}, {31'b0, (c == lat)});
            if (c == lat) checkOutput({tag, "_result"}, shfResult, expResult);
            if (c == intrudeCycle) begin
                shfReq = 1'b1;
                shfOp  = OP_SRL;
                shfLhs = 32'hFFFF_0000;
                shfRhs = 32'd1;
            end
            step();
            shfReq = 1'b0;
        end
        checkOutput({tag, "_idleValid"}, {31'b0, shfValid}, 32'd0);
        checkOutput({tag, "_idleBusy"}, {31'b0, shfBusy}, 32'd0);
        checkOutput({tag, "_hold"}, shfResult, expResult);
    endtask

    initial begin
        nAsserts = 0;
        nFail    = 0;
        reset    = 1'b1;
        shfReq   = 1'b0;
        shfLhs   = '0;
        shfRhs   = '0;
        shfOp    = OP_SLL;

        // Reset state.
        step();
        step();
        checkOutput("rst_valid", {31'b0, shfValid}, 32'd0);
        checkOutput("rst_busy", {31'b0, shfBusy}, 32'd0);
        checkOutput("rst_result", shfResult, 32'd0);
        reset = 1'b0;
        step();

        // Worst-case shift amount, then arithmetic vs logical right shift.
        runOp("sll31", OP_SLL, 32'h0000_0001, 32'd31, 32'h8000_0000, 0);
        runOp("sra4", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 0);
        runOp("srl4", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 0);
        runOp("sra16pos", OP_SRA, 32'h7FFF_0000, 32'd16, 32'h0000_7FFF, 0);
        runOp("sra31neg", OP_SRA, 32'h8000_0001, 32'd31, 32'hFFFF_FFFF, 0);

        // Upper rhs bits ignored; reserved op passes lhs through.
        runOp("rhs20", OP_SLL, 32'h1234_ABCD, 32'h0000_0020, 32'h1234_ABCD, 0);
        runOp("oprsv", OP_RSV, 32'h1234_ABCD, 32'd7, 32'h1234_ABCD, 0);

        // Request while busy is ignored; the next one right after is taken.
        runOp("busyReq", OP_SLL, 32'h0000_0003, 32'd8, 32'h0000_0300, 2);
        runOp("afterBusy", OP_SRL, 32'hA500_0000, 32'd3, 32'h14A0_0000, 0);

        // Asynchronous reset in the middle of a long shift.
        applyStimulus(OP_SRL, 32'hF000_0000, 32'd20);
        step();
        step();
        reset = 1'b1;
        #1;
        checkOutput("midRst_valid", {31'b0, shfValid}, 32'd0);
        checkOutput("midRst_busy", {31'b0, shfBusy}, 32'd0);
        checkOutput("midRst_result", shfResult, 32'd0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            checkOutput("postRst_noValid", {31'b0, shfValid}, 32'd0);
            step();
        end
        runOp("postRst", OP_SRL, 32'hF000_0000, 32'd20, 32'h0000_0F00, 0);

        // Back-to-back operations on the first idle cycle.
        runOp("b2b_sll", OP_SLL, 32'h0000_000F, 32'd4, 32'h0000_00F0, 0);
        runOp("b2b_srl", OP_SRL, 32'h0000_00F0, 32'd4, 32'h0000_000F, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/rvm_shift_unit.md
Name: rvm_shift_unit

Overview:
- Responder end of the control FSM's shift functional-unit interface (f_shf_*).
- Accepts a request strobe with operands and op, then shifts iteratively, one bit per cycle.
- Returns the 32-bit result with a single-cycle f_shf_valid pulse. Sits beside the adder and bitwise units in the core datapath.

Parameters:
- XLEN, 32, datapath width in bits; only 32 is supported.
- SHAMT_W, 5, width of the shift amount taken from f_shf_rhs[SHAMT_W-1:0].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous active-high reset.
- f_shf_req  input  1  request strobe; sampled only in IDLE.
- f_shf_lhs  input  32  value to shift.
- f_shf_rhs  input  32  shift amount; only bits [4:0] are used.
- f_shf_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
- f_shf_valid  output  1  one-cycle pulse; f_shf_result is valid in this cycle.
- f_shf_result  output  32  shift result.
- f_shf_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE; acc, count, op and f_shf_result are cleared to 0.
  - f_shf_valid=0, f_shf_busy=0; any in-flight operation is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE, with f_shf_req=1 at a rising edge:
  - Latch acc<=f_shf_lhs, count<=f_shf_rhs[4:0], op<=f_shf_op.
  - Next state is SHIFT if count is nonzero and op != 11; otherwise DONE.
- IDLE, with f_shf_req=0: stay in IDLE.
- SHIFT, every cycle:
  - SLL: acc<=acc<<1, zero fill.
  - SRL: acc<=acc>>1, zero fill.
  - SRA: acc<=acc>>1, fill with acc[31].
  - count<=count-1; when count==1 this cycle, next state is DONE.
- DONE: f_shf_valid=1 for exactly this cycle; f_shf_result<=acc (registered); next state is IDLE.
- Latency, counting from the request edge as cycle 0:
  - f_shf_valid is high in cycle k+1, where k is the effective shift amount.
  - shamt=0 or op=11 gives valid in cycle 1 with result equal to lhs.
  - Worst case is shamt=31: valid in cycle 32.
- f_shf_result holds its last value until the next DONE. It is not cleared on a new request.
- f_shf_req while busy (SHIFT or DONE) is ignored with no queuing; the control FSM must wait for valid.
- A new request can be accepted in the cycle immediately after DONE (back-to-back: one IDLE cycle between operations).
- f_shf_rhs bits [31:5] are ignored: rhs=0x20 behaves as shamt 0.
- Operand inputs are don't-care outside the accepting cycle.
- Count never wraps: it is only decremented while nonzero.

Optional Feature:
- Macro: RVM_SHIFT_FAST_EN.
- Defined: in SHIFT, if count>=4, shift acc by 4 (same fill rules) and count<=count-4; otherwise shift by 1 as normal. Valid arrives in cycle floor(k/4)+(k mod 4)+1. Example: shamt 31 gives valid in cycle 11.
- Undefined: strictly 1 bit per cycle as described above; the 4-bit shift logic is absent.
- Results are bit-identical in both builds.

Test Plan:
- SLL, lhs=0x00000001, rhs=31, req at cycle 0 -> valid only in cycle 32 (11 with FAST), result=0x80000000, busy high in cycles 1..32.
- SRA, lhs=0x80000000, rhs=4 -> result=0xF8000000, valid in cycle 5 (2 with FAST). Same operands with SRL -> 0x08000000.
- rhs=0x00000020 with SLL, lhs=0x1234ABCD -> result=0x1234ABCD, valid in cycle 1. op=11 with rhs=7 -> same result and timing.
- Second req with different operands at cycle 2 of a shamt-8 SLL -> ignored; first result is correct and valid pulses once. A req issued the cycle after valid is accepted.
- Assert reset at cycle 3 of a shamt-20 SRL -> valid, busy and result are 0 immediately and no valid appears later. A new req after reset is released completes normally.
- Back-to-back: SLL 0xF by 4, then SRL 0xF0 by 4, issued on the first IDLE cycle -> results 0xF0 then 0xF, each with a single valid pulse.
